// File: rtl/board_io_ctrl.sv
// Board I/O glue: input synchronisers, button debouncer and DUT reset sequencer.
// Optional LED heartbeat while running: define BOARD_IO_HEARTBEAT_EN.
module board_io_ctrl #(
  parameter int N_IN            = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int HB_DIV_LOG2     = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pll_locked,
  input  logic            btn_n_raw,
  input  logic [N_IN-1:0] pmod_in_raw,
  output logic [N_IN-1:0] pmod_in_sync,
  output logic            dut_rst_n,
  output logic            dut_ena,
  output logic            led_r_n,
  output logic            led_g_n
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HD_LAST = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT = 3'b001,
    HOLD = 3'b010,
    RUN  = 3'b100
  } state_e;

  logic [SYNC_STAGES-1:0]           lock_s_q;
  logic [SYNC_STAGES-1:0]           btn_s_q;
  logic [SYNC_STAGES-1:0][N_IN-1:0] pmod_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s_q <= '0;
      btn_s_q  <= '0;
      pmod_s_q <= '0;
    end else begin
      lock_s_q <= {lock_s_q[SYNC_STAGES-2:0], pll_locked};
      btn_s_q  <= {btn_s_q[SYNC_STAGES-2:0], btn_n_raw};
      pmod_s_q <= {pmod_s_q[SYNC_STAGES-2:0], pmod_in_raw};
    end
  end

  logic lock_sync;
  logic btn_sync;

  assign lock_sync    = lock_s_q[SYNC_STAGES-1];
  assign btn_sync     = btn_s_q[SYNC_STAGES-1];
  assign pmod_in_sync = pmod_s_q[SYNC_STAGES-1];

  // btn_db resets to 0 (pressed) so a fresh start needs a full release debounce
  logic          btn_db_q, btn_db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_sync != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_sync;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  logic go;
  assign go = lock_sync & btn_db_q;

  state_e        state_q, state_d;
  logic [HW-1:0] hd_cnt_q, hd_cnt_d;

  always_comb begin
    state_d  = state_q;
    hd_cnt_d = '0;
    unique case (1'b1)
      state_q[0]: begin
        if (go) state_d = HOLD;
      end
      state_q[1]: begin
        if (!go) begin
          state_d = WAIT;
        end else if (hd_cnt_q == HD_LAST) begin
          state_d = RUN;
        end else begin
          hd_cnt_d = hd_cnt_q + HW'(1);
        end
      end
      state_q[2]: begin
        if (!go) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT;
      hd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hd_cnt_q <= hd_cnt_d;
    end
  end

  // Outputs come straight off the RUN flop so they never glitch
  logic run;
  assign run       = state_q[2];
  assign dut_rst_n = run;
  assign dut_ena   = run;
  assign led_r_n   = run;

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [HB_DIV_LOG2-1:0] hb_cnt_q;
  logic                   hb_ph_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
      hb_ph_q  <= 1'b0;
    end else if (!run) begin
      hb_cnt_q <= '0;
      hb_ph_q  <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_q + HB_DIV_LOG2'(1);
      if (&hb_cnt_q) hb_ph_q <= ~hb_ph_q;
    end
  end

  assign led_g_n = ~run | hb_ph_q;
`else
  assign led_g_n = ~run;
`endif

endmodule
